rob_commit_unit: RTL and testbench
==================================

// Module: rob_commit_unit
// PURPOSE
//   In-order retirement buffer (reorder buffer) sitting between rename/dispatch and ARCH_REG_FILE.
//   - Allocates one entry per renamed instruction, in program order.
//   - Records out-of-order completion by tag.
//   - Retires the oldest completed entry each cycle.
//   - Drives the commit interface of ARCH_REG_FILE: commit_valid, commit_with_write, commited_wr_register.
// PARAMETERS
//   ROB_DEPTH               16                        entries; must be a power of 2, >= 2
//   PHYSICAL_REG_NUM_WIDTH  `PHYSICAL_REG_NUM_WIDTH   width of physical register number
//   TAG_WIDTH               $clog2(ROB_DEPTH)         entry index width (derived; do not override)
// PORTS
//   clk                   in   1          single clock, all logic on posedge
//   reset                 in   1          synchronous, active-high
//   alloc_valid           in   1          rename presents an instruction
//   alloc_ready           out  1          entry free; high when count < ROB_DEPTH
//   alloc_regwrite        in   1          instruction writes a register
//   alloc_phy_wr_reg      in   PHYS_W     physical destination register
//   alloc_tag             out  TAG_WIDTH  tag assigned to this alloc (= tail pointer)
//   complete_valid        in   1          execution finished for complete_tag
//   complete_tag          in   TAG_WIDTH  tag of the completing entry
//   flush                 in   1          discard all entries
//   commit_valid          out  1          one instruction retired (1-cycle pulse per entry)
//   commit_with_write     out  1          retired instruction wrote a register
//   commited_wr_register  out  PHYS_W     physical register of the retired instruction
//   rob_count             out  TAG_WIDTH+1  occupied entries, 0..ROB_DEPTH
//   rob_empty             out  1          rob_count == 0
// BEHAVIOUR
//   State
//   - Per entry: valid, done, regwrite, phy_reg.
//   - head_ptr, tail_ptr (TAG_WIDTH bits, wrap mod ROB_DEPTH), count register.
//   Reset (sync)
//   - All valid/done bits = 0; head = tail = count = 0.
//   - commit_valid = 0, commit_with_write = 0, commited_wr_register = 0.
//   - Hence alloc_ready = 1, rob_empty = 1, alloc_tag = 0.
//   Alloc
//   - Accepted when alloc_valid && alloc_ready.
//   - Entry[tail] <= {valid=1, done=0, regwrite, phy_reg}; tail <= tail+1.
//   - alloc_ready and alloc_tag are combinational from registered state only.
//   - alloc_ready does not anticipate a same-cycle retire: at count == ROB_DEPTH, alloc stalls even if the head retires that cycle.
//   Complete
//   - When complete_valid && entry[complete_tag].valid: done <= 1.
//   - Completion of an invalid entry is ignored, including a tag being allocated in the same cycle.
//   - A repeated completion is harmless.
//   Retire
//   - When entry[head].valid && entry[head].done (registered bits): clear valid/done, head <= head+1.
//   - Registered outputs next cycle: commit_valid = 1, commit_with_write = regwrite, commited_wr_register = regwrite ? phy_reg : 0.
//   - Otherwise commit_valid = 0 and the other two commit outputs = 0.
//   - Maximum one retire per cycle.
//   Latency
//   - complete_valid sampled at edge E -> done set after E -> retire decided at E+1 -> commit_valid high in the cycle after E+1.
//   - Minimum: alloc at E0, complete at E1, commit visible after E2.
//   Count
//   - count += alloc_accept - retire.
//   - Simultaneous alloc and retire leaves count unchanged.
//   - count never exceeds ROB_DEPTH and never underflows.
//   Wrap-around
//   - Pointers wrap ROB_DEPTH-1 -> 0.
//   - Full/empty are distinguished by count, not by pointer equality.
//   Flush
//   - Synchronous; priority over alloc, complete and retire.
//   - Next cycle: same state as reset, including commit outputs = 0.
//   - Any retire pending in the flush cycle is dropped.
//   Reset mid-operation
//   - Identical to reset; no partial commit pulses afterwards.
// TESTING
//   1. Reset 2 cycles -> rob_empty=1, alloc_ready=1, rob_count=0, alloc_tag=0, commit_valid=0.
//   2. Alloc phys 4,5,6 (regwrite=1); complete tags 2,1,0 one per cycle
//      -> commit_valid on 3 consecutive cycles, commited_wr_register 4,5,6 in order;
//         first pulse two edges after tag 0 completes.
//   3. Alloc 16 -> rob_count=16, alloc_ready=0; 17th alloc_valid ignored (tail unchanged);
//      complete tag 0 -> one commit of tag 0's reg, then alloc_ready=1, rob_count=15.
//   4. Stream 20 alloc/complete pairs -> tags wrap 15->0;
//      20 commits in alloc order; rob_count returns to 0.
//   5. Alloc regwrite=0, phys 9; complete -> commit_valid=1, commit_with_write=0, commited_wr_register=0.
//   6. 5 entries, tags 0 and 1 done, assert flush -> next cycle rob_count=0, rob_empty=1, no commit pulse;
//      next alloc gets tag 0.

Source files
------------

// File: rtl/rob_commit_unit.sv
// In-order retirement buffer: allocates entries in program order, marks them done
// out of order by tag, and retires the oldest completed entry into the commit port.
module rob_commit_unit #(
  parameter int unsigned ROB_DEPTH              = 16,
  parameter int unsigned PHYSICAL_REG_NUM_WIDTH = 6,
  localparam int unsigned TAG_WIDTH             = $clog2(ROB_DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  input  logic                              alloc_regwrite,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_wr_reg,
  output logic [TAG_WIDTH-1:0]              alloc_tag,
  input  logic                              complete_valid,
  input  logic [TAG_WIDTH-1:0]              complete_tag,
  input  logic                              flush,
  output logic                              commit_valid,
  output logic                              commit_with_write,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
  output logic [TAG_WIDTH:0]                rob_count,
  output logic                              rob_empty
);

  localparam int unsigned CNT_W = TAG_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0]              valid;
  logic [ROB_DEPTH-1:0]              done;
  logic [ROB_DEPTH-1:0]              regwrite;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] phy_reg [ROB_DEPTH];
  logic [TAG_WIDTH-1:0]              head_ptr;
  logic [TAG_WIDTH-1:0]              tail_ptr;
  logic [CNT_W-1:0]                  count;
  logic                              alloc_accept;
  logic                              retire;

  // Full/empty come from the occupancy count, never from pointer equality
  always_comb begin
    alloc_ready  = (count != FULL_COUNT);
    alloc_tag    = tail_ptr;
    rob_count    = count;
    rob_empty    = (count == '0);
    alloc_accept = alloc_valid && alloc_ready;
    retire       = valid[head_ptr] && done[head_ptr];
  end

  // Control state and commit port; flush behaves exactly like reset
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid                <= '0;
      done                 <= '0;
      head_ptr             <= '0;
      tail_ptr             <= '0;
      count                <= '0;
      commit_valid         <= 1'b0;
      commit_with_write    <= 1'b0;
      commited_wr_register <= '0;
    end else begin
      if (complete_valid && valid[complete_tag]) begin
        done[complete_tag] <= 1'b1;
      end
      // Retire clears after completion so a late duplicate completion cannot resurrect it
      if (retire) begin
        valid[head_ptr] <= 1'b0;
        done[head_ptr]  <= 1'b0;
        head_ptr        <= head_ptr + TAG_WIDTH'(1);
      end
      if (alloc_accept) begin
        valid[tail_ptr] <= 1'b1;
        done[tail_ptr]  <= 1'b0;
        tail_ptr        <= tail_ptr + TAG_WIDTH'(1);
      end
      count                <= count + CNT_W'(alloc_accept) - CNT_W'(retire);
      commit_valid         <= retire;
      commit_with_write    <= retire && regwrite[head_ptr];
      commited_wr_register <= (retire && regwrite[head_ptr]) ? phy_reg[head_ptr] : '0;
    end
  end

  // Entry payload needs no reset: it is only read while the entry is valid
  always_ff @(posedge clk) begin
    if (alloc_accept) begin
      regwrite[tail_ptr] <= alloc_regwrite;
      phy_reg[tail_ptr]  <= alloc_phy_wr_reg;
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: a hand-computed vector table, directed corner sequences,
// and randomized traffic checked against a queue-based model of the buffer.
module tb_rob_commit_unit;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, alloc_valid, alloc_ready, alloc_regwrite;
  logic [5:0] alloc_phy_wr_reg;
  logic [3:0] alloc_tag;
  logic       complete_valid;
  logic [3:0] complete_tag;
  logic       flush, commit_valid, commit_with_write;
  logic [5:0] commited_wr_register;
  logic [4:0] rob_count;
  logic       rob_empty;

  rob_commit_unit #(.ROB_DEPTH(16), .PHYSICAL_REG_NUM_WIDTH(6)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_regwrite(alloc_regwrite), .alloc_phy_wr_reg(alloc_phy_wr_reg),
    .alloc_tag(alloc_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag),
    .flush(flush),
    .commit_valid(commit_valid), .commit_with_write(commit_with_write),
    .commited_wr_register(commited_wr_register),
    .rob_count(rob_count), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Reference model: the buffer is a program-ordered queue of in-flight instructions
  typedef struct { int tag; bit rw; int phy; bit done; } ent_t;
  ent_t q[$];
  int   m_tail = 0;
  bit   m_cv = 0, m_cw = 0;
  int   m_reg = 0;

  task automatic model_edge(input bit av, rw, input int phy, input bit cv, input int ct,
                            input bit fl, rs);
    bit acc;
    if (rs || fl) begin
      q.delete(); m_tail = 0; m_cv = 0; m_cw = 0; m_reg = 0;
      return;
    end
    acc = av && (q.size() < DEPTH);
    if (q.size() > 0 && q[0].done) begin
      m_cv = 1; m_cw = q[0].rw; m_reg = q[0].rw ? q[0].phy : 0;
      q.delete(0);
    end else begin
      m_cv = 0; m_cw = 0; m_reg = 0;
    end
    if (cv) foreach (q[i]) if (q[i].tag == ct) q[i].done = 1;
    if (acc) begin
      q.push_back('{tag: m_tail, rw: rw, phy: phy, done: 1'b0});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic cycle(input bit av, rw, input int phy, input bit cv, input int ct,
                       input bit fl, rs);
    alloc_valid = av; alloc_regwrite = rw; alloc_phy_wr_reg = 6'(phy);
    complete_valid = cv; complete_tag = 4'(ct); flush = fl; reset = rs;
    @(posedge clk);
    model_edge(av, rw, phy, cv, ct, fl, rs);
    #1;
  endtask

  task automatic check(input string name, input bit ecv, ecw, input int ereg, ecnt, etag,
                       input bit erdy, eemp);
    nvec++;
    if (commit_valid !== ecv || commit_with_write !== ecw || commited_wr_register !== 6'(ereg) ||
        rob_count !== 5'(ecnt) || alloc_tag !== 4'(etag) || alloc_ready !== erdy ||
        rob_empty !== eemp) begin
      nmis++;
      $display("FAIL %s: got cv=%0b cw=%0b reg=%0d cnt=%0d tag=%0d rdy=%0b emp=%0b; want cv=%0b cw=%0b reg=%0d cnt=%0d tag=%0d rdy=%0b emp=%0b",
               name, commit_valid, commit_with_write, commited_wr_register, rob_count,
               alloc_tag, alloc_ready, rob_empty, ecv, ecw, ereg, ecnt, etag, erdy, eemp);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_cv, m_cw, m_reg, q.size(), m_tail, q.size() < DEPTH, q.size() == 0);
  endtask

  task automatic step(input string name, input bit av, rw, input int phy, input bit cv,
                      input int ct, input bit fl, rs);
    cycle(av, rw, phy, cv, ct, fl, rs);
    check_model(name);
  endtask

  typedef struct {
    bit av, rw; int phy; bit cv; int ct; bit fl;
    bit ecv, ecw; int ereg, ecnt, etag; bit erdy, eemp;
  } vec_t;

  function automatic vec_t mkv(int av, rw, phy, cv, ct, fl, ecv, ecw, ereg, ecnt, etag, erdy, eemp);
    vec_t v;
    v.av = av[0]; v.rw = rw[0]; v.phy = phy; v.cv = cv[0]; v.ct = ct; v.fl = fl[0];
    v.ecv = ecv[0]; v.ecw = ecw[0]; v.ereg = ereg; v.ecnt = ecnt; v.etag = etag;
    v.erdy = erdy[0]; v.eemp = eemp[0];
    return v;
  endfunction

  vec_t vecs[14];
  int   commits;
  int   seen[$];
  int   ct;
  bit   ok;

  initial begin
    // Out-of-order completion of three writes, then a non-writing instruction
    vecs[0]  = mkv(1,1,4, 0,0,0, 0,0,0, 1,1,1,0);
    vecs[1]  = mkv(1,1,5, 0,0,0, 0,0,0, 2,2,1,0);
    vecs[2]  = mkv(1,1,6, 0,0,0, 0,0,0, 3,3,1,0);
    vecs[3]  = mkv(0,0,0, 1,2,0, 0,0,0, 3,3,1,0);
    vecs[4]  = mkv(0,0,0, 1,1,0, 0,0,0, 3,3,1,0);
    vecs[5]  = mkv(0,0,0, 1,0,0, 0,0,0, 3,3,1,0);
    vecs[6]  = mkv(0,0,0, 0,0,0, 1,1,4, 2,3,1,0);
    vecs[7]  = mkv(0,0,0, 0,0,0, 1,1,5, 1,3,1,0);
    vecs[8]  = mkv(0,0,0, 0,0,0, 1,1,6, 0,3,1,1);
    vecs[9]  = mkv(0,0,0, 0,0,0, 0,0,0, 0,3,1,1);
    vecs[10] = mkv(1,0,9, 0,0,0, 0,0,0, 1,4,1,0);
    vecs[11] = mkv(0,0,0, 1,3,0, 0,0,0, 1,4,1,0);
    vecs[12] = mkv(0,0,0, 0,0,0, 1,0,0, 0,4,1,1);
    vecs[13] = mkv(0,0,0, 0,0,0, 0,0,0, 0,4,1,1);

    // Reset state
    cycle(0,0,0,0,0,0,1);
    cycle(0,0,0,0,0,0,1);
    check("reset", 0,0,0, 0,0,1,1);

    foreach (vecs[i]) begin
      cycle(vecs[i].av, vecs[i].rw, vecs[i].phy, vecs[i].cv, vecs[i].ct, vecs[i].fl, 0);
      check($sformatf("table[%0d]", i), vecs[i].ecv, vecs[i].ecw, vecs[i].ereg,
            vecs[i].ecnt, vecs[i].etag, vecs[i].erdy, vecs[i].eemp);
    end

    // Fill to capacity, extra alloc must stall, then retire the head
    step("full_reset", 0,0,0,0,0,0,1);
    for (int i = 0; i < DEPTH; i++) step("fill", 1,1,20+i,0,0,0,0);
    check("full", 0,0,0, 16,0,0,0);
    step("alloc_when_full", 1,1,63,0,0,0,0);
    step("complete_head", 0,0,0,1,0,0,0);
    cycle(1,1,62,0,0,0,0);
    check("retire_from_full", 1,1,20, 15,0,1,0);

    // Streaming alloc/complete pairs across the pointer wrap
    step("stream_reset", 0,0,0,0,0,0,1);
    commits = 0;
    seen.delete();
    for (int i = 0; i < 24; i++) begin
      step("stream", i < 20, 1, 10+i, i > 0 && i <= 20, (i-1) % DEPTH, 0, 0);
      if (commit_valid) begin commits++; seen.push_back(int'(commited_wr_register)); end
    end
    ok = (commits == 20) && (rob_count == 5'd0);
    foreach (seen[i]) if (seen[i] != 10+i) ok = 0;
    nvec++;
    if (!ok) begin
      nmis++;
      $display("FAIL stream_order: got %0d commits, count=%0d; want 20 commits in order, count=0",
               commits, rob_count);
    end

    // Flush with a retire pending is dropped, and tags restart from 0
    step("flush_reset", 0,0,0,0,0,0,1);
    for (int i = 0; i < 5; i++) step("flush_fill", 1,1,30+i,0,0,0,0);
    step("flush_c0", 0,0,0,1,0,0,0);
    step("flush_c1", 0,0,0,1,1,0,0);
    cycle(0,0,0,0,0,1,0);
    check("flush", 0,0,0, 0,0,1,1);
    step("flush_idle", 0,0,0,0,0,0,0);
    step("post_flush_alloc", 1,1,40,0,0,0,0);

    // Randomized traffic including flushes and mid-run resets
    for (int i = 0; i < 3000; i++) begin
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        ct = q[$urandom_range(0, q.size()-1)].tag;
      else
        ct = $urandom_range(0, DEPTH-1);
      step("random",
           $urandom_range(0, 99) < (((i / 300) % 2) ? 35 : 85),
           $urandom_range(0, 1) == 1, $urandom_range(0, 63),
           $urandom_range(0, 99) < 55, ct,
           $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
